gpio_ctrl: RTL and testbench

//   Parametrised GPIO controller; successor to the fixed 2-register GPIO device in the 0x20000000 I/O window.
//   - Per-pin direction, output latch and atomic SET/CLR.
//   - Synchronised inputs with rising/falling edge detection.
//   - Write-1-to-clear interrupt pending bits and a level irq.
//   - Sits on the shared data bus (en/write_enable/addr/data_in/data_out) beside rom and ram.

---
 rtl/gpio_ctrl_if.sv | 10 +
 rtl/gpio_ctrl.sv | 66 ++++++
 tb/tb_gpio_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/gpio_ctrl_if.sv
// gpio_ctrl_if: shared data bus (en/write_enable/addr/data_in/data_out) between a CPU-side master and a peripheral slave
interface gpio_ctrl_if;
  logic        en;
  logic [2:0]  write_enable;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  modport master(output en, write_enable, addr, data_in, input data_out);
  modport slave(input en, write_enable, addr, data_in, output data_out);
endinterface

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: GPIO block (OUT/DIR/IN/RISE/FALL/PEND/SET/CLR) on the shared bus; ports clk, rst_n (sync low), bus (slave), gpio pads, irq level
module gpio_ctrl #(
  parameter int N_GPIO      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  gpio_ctrl_if.slave        bus,
  inout  wire  [N_GPIO-1:0] gpio,
  output logic              irq
);
  logic [N_GPIO-1:0] out_r, dir_r, rise_en, fall_en, pend, prev, in_v, rise, fall, m, d, w1c;
  logic [N_GPIO-1:0] sync_q [SYNC_STAGES];
  logic [31:0] wmask, wdata, rd;
  logic [2:0] sel;
  logic wr;
  assign sel = bus.addr[4:2];
  assign wr = bus.en & |bus.write_enable;
  assign wmask = bus.write_enable[0] ? 32'hFFFF_FFFF :
                 bus.write_enable[1] ? 32'h0000_FFFF << {bus.addr[1], 4'b0000} :
                 bus.write_enable[2] ? 32'h0000_00FF << {bus.addr[1:0], 3'b000} : 32'h0;
  assign wdata = bus.write_enable[0] ? bus.data_in :
                 bus.write_enable[1] ? {2{bus.data_in[15:0]}} : {4{bus.data_in[7:0]}};
  assign m = wmask[N_GPIO-1:0];
  assign d = wdata[N_GPIO-1:0] & m;
  assign w1c = (wr && sel == 3'd5) ? d : '0;
  assign in_v = sync_q[SYNC_STAGES-1];
  assign rise = in_v & ~prev;
  assign fall = ~in_v & prev;
  assign irq = |pend;
  for (genvar g = 0; g < N_GPIO; g++) begin : g_pad
    assign gpio[g] = dir_r[g] ? out_r[g] : 1'bz;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_r   <= '0;
      dir_r   <= '0;
      rise_en <= '0;
      fall_en <= '0;
      pend    <= '0;
      prev    <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      if (wr && sel == 3'd0) out_r <= (out_r & ~m) | d;
      else if (wr && sel == 3'd6) out_r <= out_r | d;
      else if (wr && sel == 3'd7) out_r <= out_r & ~d;
      if (wr && sel == 3'd1) dir_r <= (dir_r & ~m) | d;
      if (wr && sel == 3'd3) rise_en <= (rise_en & ~m) | d;
      if (wr && sel == 3'd4) fall_en <= (fall_en & ~m) | d;
      pend <= (pend & ~w1c) | (rise & rise_en) | (fall & fall_en);
      sync_q[0] <= gpio;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= in_v;
    end
  end
  always_comb begin
    rd = '0;
    rd[N_GPIO-1:0] = sel == 3'd0 ? out_r :
                     sel == 3'd1 ? dir_r :
                     sel == 3'd2 ? in_v :
                     sel == 3'd3 ? rise_en :
                     sel == 3'd4 ? fall_en :
                     sel == 3'd5 ? pend : '0;
  end
  assign bus.data_out = bus.en ? rd >> {bus.addr[1:0], 3'b000} : 'z;
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: scoreboard bench for gpio_ctrl with directed bus and pad stimulus
module tb_gpio_ctrl;
  localparam int N = 16;
  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  logic smp = 1'b0;
  logic [N-1:0] tb_en, tb_val;
  wire  [N-1:0] gpio;
  item_t q[$];
  item_t e;
  logic [31:0] act;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  gpio_ctrl_if bus();
  for (genvar i = 0; i < N; i++) begin : g_drv
    assign gpio[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end
  gpio_ctrl #(.N_GPIO(N), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .gpio(gpio),
    .irq(irq)
  );
  always @(negedge clk) begin
    if (smp) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty actual=none required=item");
      end else begin
        e = q.pop_front();
        act = e.kind == 0 ? bus.data_out : e.kind == 1 ? {24'h0, gpio[7:0]} : {31'h0, irq};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
        end
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr(input logic [2:0] we, input logic [31:0] a, input logic [31:0] dat);
    bus.en = 1'b1;
    bus.write_enable = we;
    bus.addr = a;
    bus.data_in = dat;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    bus.write_enable = 3'b000;
  endtask
  task automatic chk(input int k, input logic [31:0] a, input logic [31:0] ex, input string nm);
    q.push_back('{k, ex, nm});
    if (k == 0) begin
      bus.en = 1'b1;
      bus.addr = a;
    end
    smp = 1'b1;
    @(posedge clk);
    #1;
    smp = 1'b0;
    bus.en = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
  initial begin
    bus.en = 1'b0;
    bus.write_enable = 3'b000;
    bus.addr = '0;
    bus.data_in = '0;
    tb_en = 16'h00FF;
    tb_val = '0;
    idle(3);
    rst_n = 1'b1;
    idle(3);
    for (int r = 0; r < 8; r++) chk(0, 32'h2000_0000 + r * 4, 32'h0, $sformatf("reset_reg%0d", r));
    chk(2, 0, 32'h0, "reset_irq");
    wr(3'b100, 32'h2000_0005, 32'h0000_003C);
    chk(0, 32'h2000_0005, 32'h0000_003C, "dir_byte_lane1");
    chk(0, 32'h2000_0004, 32'h0000_3C00, "dir_word_read");
    wr(3'b010, 32'h2000_000C, 32'h0000_1234);
    wr(3'b010, 32'h2000_000E, 32'h0000_FFFF);
    chk(0, 32'h2000_000C, 32'h0000_1234, "rise_half_upper_ignored");
    wr(3'b110, 32'h2000_0011, 32'h0000_5678);
    chk(0, 32'h2000_0010, 32'h0000_5678, "half_beats_byte");
    wr(3'b111, 32'h2000_0012, 32'h0000_0000);
    chk(0, 32'h2000_0010, 32'h0000_0000, "word_beats_half");
    wr(3'b001, 32'h2000_000C, 32'h0);
    wr(3'b001, 32'h2000_0004, 32'h0000_00FF);
    tb_en = 16'hFF00;
    wr(3'b001, 32'h2000_0000, 32'h0000_00A5);
    chk(1, 0, 32'h0000_00A5, "pads_out_a5");
    wr(3'b001, 32'h2000_0018, 32'h0000_000A);
    chk(1, 0, 32'h0000_00AF, "pads_set");
    wr(3'b001, 32'h2000_001C, 32'h0000_0081);
    chk(1, 0, 32'h0000_002E, "pads_clr");
    chk(0, 32'h2000_0000, 32'h0000_002E, "out_read");
    chk(0, 32'h2000_0018, 32'h0, "set_reads_zero");
    chk(0, 32'h2000_0008, 32'h0000_002E, "in_samples_driven_pads");
    wr(3'b001, 32'h2000_0004, 32'hFFFF_00FF);
    chk(0, 32'h2000_0004, 32'h0000_00FF, "dir_upper_ignored");
    wr(3'b001, 32'h2000_0004, 32'h0);
    tb_en = 16'hFFFF;
    tb_val = '0;
    idle(4);
    chk(0, 32'h2000_0014, 32'h0, "pend_none_while_disabled");
    wr(3'b001, 32'h2000_000C, 32'h0000_0008);
    tb_val[3] = 1'b1;
    chk(0, 32'h2000_0008, 32'h0, "in_lat0");
    chk(0, 32'h2000_0008, 32'h0, "in_lat1");
    chk(0, 32'h2000_0008, 32'h0000_0008, "in_lat2");
    chk(0, 32'h2000_0014, 32'h0000_0008, "pend_rise");
    chk(2, 0, 32'h1, "irq_rise");
    wr(3'b001, 32'h2000_0014, 32'h0000_0008);
    chk(2, 0, 32'h0, "irq_after_w1c");
    chk(0, 32'h2000_0014, 32'h0, "pend_after_w1c");
    tb_val[3] = 1'b0;
    idle(4);
    chk(0, 32'h2000_0014, 32'h0, "pend_before_race");
    tb_val[3] = 1'b1;
    idle(2);
    wr(3'b001, 32'h2000_0014, 32'h0000_0008);
    chk(0, 32'h2000_0014, 32'h0000_0008, "pend_set_wins");
    chk(2, 0, 32'h1, "irq_set_wins");
    wr(3'b001, 32'h2000_0014, 32'h0000_FFFF);
    wr(3'b001, 32'h2000_0010, 32'h0000_0001);
    tb_val[0] = 1'b1;
    idle(1);
    tb_val[0] = 1'b0;
    idle(1);
    rst_n = 1'b0;
    wr(3'b001, 32'h2000_0000, 32'h0000_00FF);
    idle(1);
    rst_n = 1'b1;
    idle(4);
    chk(0, 32'h2000_0014, 32'h0, "rst_pend");
    chk(2, 0, 32'h0, "rst_irq");
    chk(0, 32'h2000_0000, 32'h0, "rst_out_write_discarded");
    chk(0, 32'h2000_0004, 32'h0, "rst_dir");
    chk(0, 32'h2000_000C, 32'h0, "rst_rise");
    chk(0, 32'h2000_0010, 32'h0, "rst_fall");
    chk(0, 32'h2000_0008, 32'h0000_0008, "rst_in_resampled");
    wr(3'b001, 32'h2000_000C, 32'h0000_0008);
    idle(2);
    chk(0, 32'h2000_0014, 32'h0, "no_replay");
    idle(2);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
